// File: rtl/homa_defs.sv
// Shared Homa definitions: SRPT grant-queue entry layout, SRPT codes and packet type codes.
package homa_defs;

   localparam int unsigned ENTRY_SIZE = 51;

   localparam int unsigned PEER_ID_HI      = 50;
   localparam int unsigned PEER_ID_LO      = 37;
   localparam int unsigned RPC_ID_HI       = 36;
   localparam int unsigned RPC_ID_LO       = 23;
   localparam int unsigned RECV_PKTS_HI    = 22;
   localparam int unsigned RECV_PKTS_LO    = 13;
   localparam int unsigned GRNTBLE_PKTS_HI = 12;
   localparam int unsigned GRNTBLE_PKTS_LO = 3;
   localparam int unsigned CODE_HI         = 2;
   localparam int unsigned CODE_LO         = 0;

   localparam int unsigned PEER_ID_W = PEER_ID_HI - PEER_ID_LO + 1;
   localparam int unsigned RPC_ID_W  = RPC_ID_HI - RPC_ID_LO + 1;
   localparam int unsigned PKTS_W    = RECV_PKTS_HI - RECV_PKTS_LO + 1;
   localparam int unsigned KEY_W     = PEER_ID_W + RPC_ID_W;
   localparam int unsigned OFFSET_W  = PKTS_W + 1;

   localparam logic [2:0] SRPT_UPDATE       = 3'b000;
   localparam logic [2:0] SRPT_BLOCK        = 3'b001;
   localparam logic [2:0] SRPT_UNBLOCK      = 3'b010;
   localparam logic [2:0] SRPT_EMPTY        = 3'b011;
   localparam logic [2:0] SRPT_INVALIDATE   = 3'b100;
   localparam logic [2:0] SRPT_DBUFF_UPDATE = 3'b101;
   localparam logic [2:0] SRPT_ACTIVE       = 3'b110;

   localparam logic [7:0] HOMA_GRANT_TYPE = 8'h12;

   typedef enum logic [1:0] {StIdle, StEval, StBeat0, StBeat1} tx_state_e;

endpackage

// File: rtl/grant_offset_cam.sv
// Last-granted-offset tracking CAM keyed on {peer_id, rpc_id}; combinational lookup,
// registered write/clear, round-robin allocation on a miss.
module grant_offset_cam
   import homa_defs::*;
#(
   parameter int unsigned NUM_TRACK      = 16,
   parameter int unsigned NUM_TRACK_LOG2 = 4
) (
   input  logic                      ap_clk,
   input  logic                      ap_rst,
   input  logic [KEY_W-1:0]          lookup_key_i,
   output logic                      lookup_hit_o,
   output logic [NUM_TRACK_LOG2-1:0] lookup_idx_o,
   output logic [OFFSET_W-1:0]       lookup_offset_o,
   input  logic                      wr_en_i,
   input  logic [KEY_W-1:0]          wr_key_i,
   input  logic [OFFSET_W-1:0]       wr_offset_i,
   input  logic                      wr_hit_i,
   input  logic [NUM_TRACK_LOG2-1:0] wr_idx_i,
   input  logic                      clr_en_i,
   input  logic [KEY_W-1:0]          clr_key_i
);

   logic [NUM_TRACK-1:0]      valid_q;
   logic [KEY_W-1:0]          key_q   [NUM_TRACK];
   logic [OFFSET_W-1:0]       off_q   [NUM_TRACK];
   logic [NUM_TRACK_LOG2-1:0] alloc_q;
   logic [NUM_TRACK_LOG2-1:0] hit_idx;

   // Scan downward so the lowest matching index wins.
   always_comb begin
      lookup_hit_o = 1'b0;
      hit_idx      = '0;
      for (int i = NUM_TRACK - 1; i >= 0; i--) begin
         if (valid_q[i] && key_q[i] == lookup_key_i) begin
            lookup_hit_o = 1'b1;
            hit_idx      = NUM_TRACK_LOG2'(i);
         end
      end
   end

   assign lookup_idx_o    = hit_idx;
   assign lookup_offset_o = off_q[hit_idx];

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         valid_q <= '0;
         alloc_q <= '0;
         for (int i = 0; i < NUM_TRACK; i++) begin
            key_q[i] <= '0;
            off_q[i] <= '0;
         end
      end else begin
         if (wr_en_i) begin
            if (wr_hit_i) begin
               off_q[wr_idx_i] <= wr_offset_i;
            end else begin
               valid_q[alloc_q] <= 1'b1;
               key_q[alloc_q]   <= wr_key_i;
               off_q[alloc_q]   <= wr_offset_i;
               alloc_q          <= alloc_q + 1'b1;
            end
         end
         if (clr_en_i) begin
            for (int i = 0; i < NUM_TRACK; i++) begin
               if (valid_q[i] && key_q[i] == clr_key_i) begin
                  valid_q[i] <= 1'b0;
               end
            end
         end
      end
   end

endmodule

// File: rtl/grant_pkt_tx.sv
// Pops SRPT grant entries, suppresses non-advancing grants and serialises surviving
// grants as a two-beat Homa GRANT header on a valid/ready stream.
module grant_pkt_tx
   import homa_defs::*;
#(
   parameter int unsigned GRANT_WINDOW_PKTS = 8,
   parameter int unsigned PKT_BYTES_LOG2    = 10,
   parameter int unsigned NUM_TRACK         = 16,
   parameter int unsigned NUM_TRACK_LOG2    = 4,
   parameter logic [2:0]  SCHED_PRIO        = 3'd7
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  grant_pkt_empty_i,
   output logic                  grant_pkt_read_en_o,
   input  logic [ENTRY_SIZE-1:0] grant_pkt_data_i,
   output logic                  grant_out_valid_o,
   input  logic                  grant_out_ready_i,
   output logic [63:0]           grant_out_data_o,
   output logic                  grant_out_last_o,
   output logic [15:0]           grants_sent_o,
   output logic [15:0]           grants_dropped_o
);

   tx_state_e             state_q;
   logic [ENTRY_SIZE-1:0] entry_q;

   logic [PEER_ID_W-1:0] peer_id;
   logic [RPC_ID_W-1:0]  rpc_id;
   logic [PKTS_W-1:0]    recv_pkts;
   logic [PKTS_W-1:0]    grntble_pkts;
   logic [2:0]           code;
   logic [KEY_W-1:0]     key;
   logic [PKTS_W-1:0]    window_pkts;
   logic [OFFSET_W-1:0]  offset_pkts;
   logic [31:0]          offset_bytes;
   logic [63:0]          beat0_data;
   logic [63:0]          beat1_data;

   logic                      cam_hit;
   logic [NUM_TRACK_LOG2-1:0] cam_idx;
   logic [OFFSET_W-1:0]       cam_offset;
   logic                      cam_wr_en;
   logic                      cam_clr_en;

   assign peer_id      = entry_q[PEER_ID_HI:PEER_ID_LO];
   assign rpc_id       = entry_q[RPC_ID_HI:RPC_ID_LO];
   assign recv_pkts    = entry_q[RECV_PKTS_HI:RECV_PKTS_LO];
   assign grntble_pkts = entry_q[GRNTBLE_PKTS_HI:GRNTBLE_PKTS_LO];
   assign code         = entry_q[CODE_HI:CODE_LO];
   assign key          = {peer_id, rpc_id};

   assign window_pkts  = (grntble_pkts > PKTS_W'(GRANT_WINDOW_PKTS)) ?
                         PKTS_W'(GRANT_WINDOW_PKTS) : grntble_pkts;
   assign offset_pkts  = OFFSET_W'(recv_pkts) + OFFSET_W'(window_pkts);
   assign offset_bytes = 32'(offset_pkts) << PKT_BYTES_LOG2;

   assign beat0_data = {HOMA_GRANT_TYPE, peer_id, rpc_id, 28'd0};
   assign beat1_data = {offset_bytes, SCHED_PRIO, 29'd0};

   // The entry register holds the key through BEAT1, so the lookup result is still
   // valid when the CAM is written on the final handshake.
   assign cam_wr_en  = (state_q == StBeat1) && grant_out_ready_i;
   assign cam_clr_en = (state_q == StEval) && (code == SRPT_BLOCK);

   grant_offset_cam #(
      .NUM_TRACK      (NUM_TRACK),
      .NUM_TRACK_LOG2 (NUM_TRACK_LOG2)
   ) u_cam (
      .ap_clk          (ap_clk),
      .ap_rst          (ap_rst),
      .lookup_key_i    (key),
      .lookup_hit_o    (cam_hit),
      .lookup_idx_o    (cam_idx),
      .lookup_offset_o (cam_offset),
      .wr_en_i         (cam_wr_en),
      .wr_key_i        (key),
      .wr_offset_i     (offset_pkts),
      .wr_hit_i        (cam_hit),
      .wr_idx_i        (cam_idx),
      .clr_en_i        (cam_clr_en),
      .clr_key_i       (key)
   );

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q             <= StIdle;
         entry_q             <= '0;
         grant_pkt_read_en_o <= 1'b0;
         grant_out_valid_o   <= 1'b0;
         grant_out_data_o    <= '0;
         grant_out_last_o    <= 1'b0;
         grants_sent_o       <= '0;
         grants_dropped_o    <= '0;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (!grant_pkt_empty_i) begin
                  entry_q             <= grant_pkt_data_i;
                  grant_pkt_read_en_o <= 1'b1;
                  state_q             <= StEval;
               end
            end
            StEval: begin
               grant_pkt_read_en_o <= 1'b0;
               if (code == SRPT_ACTIVE && !(cam_hit && offset_pkts <= cam_offset)) begin
                  grant_out_valid_o <= 1'b1;
                  grant_out_data_o  <= beat0_data;
                  grant_out_last_o  <= 1'b0;
                  state_q           <= StBeat0;
               end else begin
                  grants_dropped_o <= grants_dropped_o + 16'd1;
                  state_q          <= StIdle;
               end
            end
            StBeat0: begin
               if (grant_out_ready_i) begin
                  grant_out_data_o <= beat1_data;
                  grant_out_last_o <= 1'b1;
                  state_q          <= StBeat1;
               end
            end
            StBeat1: begin
               if (grant_out_ready_i) begin
                  grant_out_valid_o <= 1'b0;
                  grant_out_data_o  <= '0;
                  grant_out_last_o  <= 1'b0;
                  grants_sent_o     <= grants_sent_o + 16'd1;
                  state_q           <= StIdle;
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_grant_pkt_tx.sv
// Directed bench for grant_pkt_tx with a beat scoreboard and stream protocol monitor.
module tb_grant_pkt_tx;
   import homa_defs::*;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        empty;
   logic        rd_en;
   logic [50:0] din;
   logic        valid;
   logic        ready;
   logic [63:0] dout;
   logic        last;
   logic [15:0] sent;
   logic [15:0] dropped;

   always #5 ap_clk = ~ap_clk;

   grant_pkt_tx dut (
      .ap_clk              (ap_clk),
      .ap_rst              (ap_rst),
      .grant_pkt_empty_i   (empty),
      .grant_pkt_read_en_o (rd_en),
      .grant_pkt_data_i    (din),
      .grant_out_valid_o   (valid),
      .grant_out_ready_i   (ready),
      .grant_out_data_o    (dout),
      .grant_out_last_o    (last),
      .grants_sent_o       (sent),
      .grants_dropped_o    (dropped)
   );

   logic [64:0] exp_q[$];
   int n_checks = 0;
   int n_err    = 0;
   int exp_sent = 0;
   int exp_dropped = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      #1;
   endtask

   // Present one FIFO entry and wait for its pop; returns edges taken until read_en seen.
   task automatic send(input logic [13:0] peer, input logic [13:0] rpc, input logic [9:0] recv,
                       input logic [9:0] gr, input logic [2:0] code, input bit emit,
                       input logic [31:0] off_b, output int cyc);
      bit got;
      if (emit) begin
         exp_q.push_back({8'h12, peer, rpc, 28'd0, 1'b0});
         exp_q.push_back({off_b, 3'd7, 29'd0, 1'b1});
         exp_sent++;
      end else begin
         exp_dropped++;
      end
      din   = {peer, rpc, recv, gr, code};
      empty = 1'b0;
      got   = 1'b0;
      cyc   = 0;
      while (!got && cyc < 50) begin
         tick();
         cyc++;
         if (rd_en) got = 1'b1;
      end
      empty = 1'b1;
      chk("pop_seen", 64'(got), 64'd1);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 100) begin
         tick();
         t++;
      end
      chk("drain_in_time", 64'(t < 100), 64'd1);
      tick();
      tick();
   endtask

   // Monitor: pops the scoreboard on each handshake and checks stream stability rules.
   logic        pv, pr, pl, pre;
   logic [63:0] pd;
   always @(negedge ap_clk) begin
      logic [64:0] e;
      if (ap_rst) begin
         pv  = 1'b0;
         pre = 1'b0;
      end else begin
         if (pre) chk("read_en_single_cycle", 64'(rd_en), 64'd0);
         if (pv && !pr) begin
            chk("hold_valid", 64'(valid), 64'd1);
            chk("hold_data", dout, pd);
            chk("hold_last", 64'(last), 64'(pl));
         end
         if (valid && ready) begin
            if (exp_q.size() == 0) begin
               chk("beat_expected", 64'(exp_q.size()), 64'd1);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", dout, e[64:1]);
               chk("beat_last", 64'(last), 64'(e[0]));
            end
         end
         pv  = valid;
         pr  = ready;
         pd  = dout;
         pl  = last;
         pre = rd_en;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int cyc;
      ap_rst = 1'b1;
      empty  = 1'b1;
      ready  = 1'b1;
      din    = '0;
      tick();
      tick();
      ap_rst = 1'b0;
      tick();
      chk("rst_read_en", 64'(rd_en), 64'd0);
      chk("rst_valid", 64'(valid), 64'd0);
      chk("rst_data", dout, 64'd0);
      chk("rst_last", 64'(last), 64'd0);
      chk("rst_sent", 64'(sent), 64'd0);
      chk("rst_dropped", 64'(dropped), 64'd0);

      // First grant with latency checks
      send(14'd5, 14'd9, 10'd3, 10'd20, SRPT_ACTIVE, 1'b1, 32'd11264, cyc);
      chk("lat_read_en", 64'(cyc), 64'd1);
      chk("lat_valid_not_yet", 64'(valid), 64'd0);
      tick();
      chk("lat_read_en_low", 64'(rd_en), 64'd0);
      chk("lat_valid", 64'(valid), 64'd1);
      chk("first_beat0", dout, {8'h12, 14'd5, 14'd9, 28'd0});
      drain();
      chk("sent_1", 64'(sent), 64'd1);
      chk("dropped_0", 64'(dropped), 64'd0);

      // Non-advancing repeat is suppressed, advancing one is emitted
      send(14'd5, 14'd9, 10'd3, 10'd20, SRPT_ACTIVE, 1'b0, 32'd0, cyc);
      drain();
      chk("dup_dropped", 64'(dropped), 64'd1);
      chk("dup_sent", 64'(sent), 64'd1);
      send(14'd5, 14'd9, 10'd4, 10'd20, SRPT_ACTIVE, 1'b1, 32'd12288, cyc);
      drain();
      chk("adv_sent", 64'(sent), 64'd2);

      // Backpressure during BEAT0
      ready = 1'b0;
      send(14'd7, 14'd1, 10'd0, 10'd5, SRPT_ACTIVE, 1'b1, 32'd5120, cyc);
      tick();
      chk("bp_valid_up", 64'(valid), 64'd1);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("bp_valid", 64'(valid), 64'd1);
         chk("bp_data", dout, {8'h12, 14'd7, 14'd1, 28'd0});
         chk("bp_last", 64'(last), 64'd0);
      end
      ready = 1'b1;
      tick();
      chk("bp_beat1_last", 64'(last), 64'd1);
      chk("bp_beat1_data", dout, {32'd5120, 3'd7, 29'd0});
      drain();

      // BLOCK clears suppression history
      send(14'd5, 14'd9, 10'd0, 10'd0, SRPT_BLOCK, 1'b0, 32'd0, cyc);
      send(14'd5, 14'd9, 10'd3, 10'd20, SRPT_ACTIVE, 1'b1, 32'd11264, cyc);
      drain();
      chk("block_dropped", 64'(dropped), 64'(exp_dropped));
      chk("block_sent", 64'(sent), 64'(exp_sent));

      // 17 distinct keys wrap the CAM and evict key #1
      for (int i = 0; i < 17; i++) begin
         send(14'(100 + i), 14'(i), 10'(i), 10'd8, SRPT_ACTIVE, 1'b1, 32'((i + 8) << 10), cyc);
      end
      drain();
      send(14'd100, 14'd0, 10'd0, 10'd8, SRPT_ACTIVE, 1'b1, 32'd8192, cyc);
      send(14'd105, 14'd5, 10'd5, 10'd8, SRPT_ACTIVE, 1'b0, 32'd0, cyc);
      send(14'd1, 14'd2, 10'd3, 10'd4, SRPT_UPDATE, 1'b0, 32'd0, cyc);
      drain();
      chk("wrap_sent", 64'(sent), 64'(exp_sent));
      chk("wrap_dropped", 64'(dropped), 64'(exp_dropped));

      // Reset mid-BEAT1
      ready = 1'b0;
      send(14'd9, 14'd9, 10'd1, 10'd1, SRPT_ACTIVE, 1'b1, 32'd2048, cyc);
      tick();
      ready = 1'b1;
      tick();
      chk("pre_rst_beat1", 64'(last), 64'd1);
      ready = 1'b0;
      #1;
      ap_rst = 1'b1;
      #1;
      chk("mid_rst_read_en", 64'(rd_en), 64'd0);
      chk("mid_rst_valid", 64'(valid), 64'd0);
      chk("mid_rst_data", dout, 64'd0);
      chk("mid_rst_last", 64'(last), 64'd0);
      chk("mid_rst_sent", 64'(sent), 64'd0);
      chk("mid_rst_dropped", 64'(dropped), 64'd0);
      exp_q.delete();
      exp_sent    = 0;
      exp_dropped = 0;
      tick();
      ap_rst = 1'b0;
      ready  = 1'b1;
      tick();
      send(14'd5, 14'd9, 10'd3, 10'd20, SRPT_ACTIVE, 1'b1, 32'd11264, cyc);
      chk("post_rst_lat_read_en", 64'(cyc), 64'd1);
      tick();
      chk("post_rst_lat_valid", 64'(valid), 64'd1);
      drain();
      chk("post_rst_sent", 64'(sent), 64'd1);

      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
      chk("final_sent", 64'(sent), 64'(exp_sent));
      chk("final_dropped", 64'(dropped), 64'(exp_dropped));
      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
